// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - size codes and drain FSM state for the store buffer
package store_buffer_pkg;

    localparam logic [1:0] SB_SIZE_B = 2'b00;
    localparam logic [1:0] SB_SIZE_H = 2'b01;
    localparam logic [1:0] SB_SIZE_W = 2'b10;

    typedef enum logic {
        SB_IDLE  = 1'b0,
        SB_WRITE = 1'b1
    } sb_state_t;

endpackage

// File: rtl/sb_lane_align.sv
// rtl/sb_lane_align.sv - shifts right-aligned store data onto byte lanes and builds the write mask
module sb_lane_align
    import store_buffer_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  wmask
);

    always_comb begin
        wdata = data;
        wmask = 4'b1111;
        case (size)
            SB_SIZE_B: begin
                wmask = 4'b0001 << addr;
                wdata = data << {addr, 3'b000};
            end
            // Halfwords use only addr[1]; a misaligned addr[0] is ignored
            SB_SIZE_H: begin
                wmask = addr[1] ? 4'b1100 : 4'b0011;
                wdata = addr[1] ? (data << 16) : data;
            end
            default: begin
                wmask = 4'b1111;
                wdata = data;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store queue: holds resolved stores until commit, drains to memory
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    input  logic [TAG_W-1:0]  st_tag,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [1:0]        st_size,
    output logic              st_ready,
    input  logic              commit_valid,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic              br,
    input  logic              check_load_enable,
    input  logic [ADDR_W-1:0] check_load_addr,
    output logic              can_load_enable,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [3:0]        mem_wmask,
    input  logic              mem_ack,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  cmt_q;
    logic [DEPTH-1:0]  cmt_next;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [1:0]        size_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  cmt_count;
    sb_state_t         state_q;

    logic        push;
    logic        pop;
    logic [31:0] head_wdata;
    logic [3:0]  head_wmask;

    assign st_ready = (count_q < CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign push     = st_valid && st_ready && !br;
    assign pop      = (state_q == SB_WRITE) && mem_ack;

    // Commit is folded in before the flush so a same-cycle commit survives it
    always_comb begin
        cmt_next  = cmt_q;
        cmt_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid && commit_tag != '0 && valid_q[i] && tag_q[i] == commit_tag)
                cmt_next[i] = 1'b1;
            if (valid_q[i] && cmt_next[i])
                cmt_count = cmt_count + CNT_W'(1);
        end
    end

    always_comb begin
        can_load_enable = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (check_load_enable && valid_q[i] && ((addr_q[i] ^ check_load_addr) >> 2) == '0)
                can_load_enable = 1'b0;
        end
    end

    sb_lane_align u_align (
        .addr  (addr_q[head_q][1:0]),
        .size  (size_q[head_q]),
        .data  (data_q[head_q]),
        .wdata (head_wdata),
        .wmask (head_wmask)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            cmt_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            state_q    <= SB_IDLE;
            mem_req    <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            mem_wmask  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
                size_q[i] <= '0;
            end
        end else begin
            cmt_q <= cmt_next;
            if (br) begin
                valid_q <= valid_q & cmt_next;
                cmt_q   <= cmt_next & valid_q;
                tail_q  <= head_q + PTR_W'(cmt_count);
                count_q <= cmt_count - CNT_W'(pop);
            end else begin
                if (push) begin
                    valid_q[tail_q] <= 1'b1;
                    cmt_q[tail_q]   <= 1'b0;
                    tag_q[tail_q]   <= st_tag;
                    addr_q[tail_q]  <= st_addr;
                    data_q[tail_q]  <= st_data;
                    size_q[tail_q]  <= st_size;
                    tail_q          <= tail_q + PTR_W'(1);
                end
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                cmt_q[head_q]   <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end

            case (state_q)
                SB_IDLE: begin
                    if (valid_q[head_q] && cmt_q[head_q]) begin
                        state_q    <= SB_WRITE;
                        mem_req    <= 1'b1;
                        mem_addr_o <= {addr_q[head_q][ADDR_W-1:2], 2'b00};
                        mem_data_o <= head_wdata;
                        mem_wmask  <= head_wmask;
                    end
                end
                SB_WRITE: begin
                    if (mem_ack) begin
                        state_q    <= SB_IDLE;
                        mem_req    <= 1'b0;
                        mem_addr_o <= '0;
                        mem_data_o <= '0;
                        mem_wmask  <= '0;
                    end
                end
                default: state_q <= SB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed vector bench for store_buffer
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st_valid = 1'b0;
    logic [7:0]  st_tag = '0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_size = '0;
    logic        st_ready;
    logic        commit_valid = 1'b0;
    logic [7:0]  commit_tag = '0;
    logic        br = 1'b0;
    logic        check_load_enable = 1'b0;
    logic [31:0] check_load_addr = '0;
    logic        can_load_enable;
    logic        mem_req;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_wmask;
    logic        mem_ack = 1'b0;
    logic        empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .st_valid          (st_valid),
        .st_tag            (st_tag),
        .st_addr           (st_addr),
        .st_data           (st_data),
        .st_size           (st_size),
        .st_ready          (st_ready),
        .commit_valid      (commit_valid),
        .commit_tag        (commit_tag),
        .br                (br),
        .check_load_enable (check_load_enable),
        .check_load_addr   (check_load_addr),
        .can_load_enable   (can_load_enable),
        .mem_req           (mem_req),
        .mem_addr_o        (mem_addr_o),
        .mem_data_o        (mem_data_o),
        .mem_wmask         (mem_wmask),
        .mem_ack           (mem_ack),
        .empty             (empty)
    );

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz);
        st_valid = 1'b1; st_tag = tag; st_addr = a; st_data = d; st_size = sz;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic commit(input logic [7:0] tag);
        commit_valid = 1'b1; commit_tag = tag;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        for (int k = 0; k < 20 && !mem_req; k++) tick();
        chk({nm, "_req"}, 32'(mem_req), 32'd1);
    endtask

    task automatic ack();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF};
        vecs[1] = '{2'b00, 32'h0000_0203, 32'h0000_005A, 32'h0000_0200, 4'b1000, 32'h5A00_0000};
        vecs[2] = '{2'b00, 32'h0000_0301, 32'h0000_00A5, 32'h0000_0300, 4'b0010, 32'h0000_A500};
        vecs[3] = '{2'b01, 32'h0000_0402, 32'h0000_BEEF, 32'h0000_0400, 4'b1100, 32'hBEEF_0000};
        vecs[4] = '{2'b01, 32'h0000_0501, 32'h0000_1234, 32'h0000_0500, 4'b0011, 32'h0000_1234};
        vecs[5] = '{2'b11, 32'h0000_0603, 32'hCAFE_F00D, 32'h0000_0600, 4'b1111, 32'hCAFE_F00D};
        vecs[6] = '{2'b00, 32'h0000_0700, 32'h0000_0077, 32'h0000_0700, 4'b0001, 32'h0000_0077};

        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_wmask", 32'(mem_wmask), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // Lane/mask vectors: each store pushed, committed and drained alone
        for (int i = 0; i < 7; i++) begin
            push(8'(i + 5), vecs[i].addr, vecs[i].data, vecs[i].size);
            chk($sformatf("v%0d_not_empty", i), 32'(empty), 32'd0);
            commit(8'(i + 5));
            wait_req($sformatf("v%0d", i));
            chk($sformatf("v%0d_addr", i), mem_addr_o, vecs[i].exp_addr);
            chk($sformatf("v%0d_mask", i), 32'(mem_wmask), 32'(vecs[i].exp_mask));
            chk($sformatf("v%0d_data", i), mem_data_o, vecs[i].exp_data);
            tick();
            chk($sformatf("v%0d_hold_req", i), 32'(mem_req), 32'd1);
            chk($sformatf("v%0d_hold_addr", i), mem_addr_o, vecs[i].exp_addr);
            ack();
            chk($sformatf("v%0d_req_drop", i), 32'(mem_req), 32'd0);
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'd1);
        end

        // Full: four uncommitted stores, fifth dropped
        for (int i = 1; i <= 4; i++) push(8'(i), 32'h1000 + 32'(i * 4), 32'(i), 2'b10);
        chk("full_st_ready", 32'(st_ready), 32'd0);
        push(8'd9, 32'h2000, 32'h9, 2'b10);
        chk("full_st_ready2", 32'(st_ready), 32'd0);
        check_load_enable = 1'b1; check_load_addr = 32'h2000;
        #1 chk("full_dropped_not_visible", 32'(can_load_enable), 32'd1);
        check_load_enable = 1'b0;
        commit(8'd1);
        wait_req("full");
        chk("full_addr", mem_addr_o, 32'h1004);
        ack();
        chk("full_ready_after_pop", 32'(st_ready), 32'd1);
        br = 1'b1; tick(); br = 1'b0;
        chk("full_flush_empty", 32'(empty), 32'd1);

        // Load address check against a buffered word
        push(8'd6, 32'h40, 32'h1111_2222, 2'b10);
        check_load_enable = 1'b1; check_load_addr = 32'h42;
        #1 chk("ld_hit", 32'(can_load_enable), 32'd0);
        check_load_addr = 32'h44;
        #1 chk("ld_miss", 32'(can_load_enable), 32'd1);
        check_load_enable = 1'b0; check_load_addr = 32'h40;
        #1 chk("ld_disabled", 32'(can_load_enable), 32'd1);
        check_load_enable = 1'b1;
        commit(8'd6);
        wait_req("ld");
        chk("ld_inflight_hit", 32'(can_load_enable), 32'd0);
        ack();
        chk("ld_after_ack", 32'(can_load_enable), 32'd1);
        check_load_enable = 1'b0;
        tick();

        // Flush keeps committed head, tail lands right after it
        push(8'd1, 32'h80, 32'hA, 2'b10);
        push(8'd2, 32'h84, 32'hB, 2'b10);
        push(8'd3, 32'h88, 32'hC, 2'b10);
        commit(8'd1);
        br = 1'b1; tick(); br = 1'b0;
        check_load_enable = 1'b1; check_load_addr = 32'h84;
        #1 chk("br_tag2_gone", 32'(can_load_enable), 32'd1);
        check_load_addr = 32'h88;
        #1 chk("br_tag3_gone", 32'(can_load_enable), 32'd1);
        check_load_enable = 1'b0;
        wait_req("br");
        chk("br_addr", mem_addr_o, 32'h80);
        ack();
        chk("br_empty", 32'(empty), 32'd1);
        tick();
        push(8'd4, 32'hC0, 32'hD, 2'b10);
        commit(8'd4);
        wait_req("br_tail");
        chk("br_tail_addr", mem_addr_o, 32'hC0);
        ack();
        tick();

        // Commit and flush in the same cycle: commit wins for that entry
        push(8'd7, 32'hD0, 32'hE, 2'b10);
        push(8'd8, 32'hD4, 32'hF, 2'b10);
        commit_valid = 1'b1; commit_tag = 8'd7; br = 1'b1;
        tick();
        commit_valid = 1'b0; br = 1'b0;
        wait_req("cbr");
        chk("cbr_addr", mem_addr_o, 32'hD0);
        ack();
        chk("cbr_empty", 32'(empty), 32'd1);
        tick();

        // Async reset in the middle of a write
        push(8'd5, 32'h100, 32'hDEAD_BEEF, 2'b10);
        commit(8'd5);
        wait_req("arst");
        #2 rst = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_ready", 32'(st_ready), 32'd1);
        chk("arst_data", mem_data_o, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
